dmem_scheduler: RTL and testbench

//  Shares the dual-port dmem (port0 write, port1 read, active-low csb) among NUM_REQ requesters
//  (LSU load path, LSU store path, future cache refill/debug). Each cycle grants at most one

---
 rtl/dmem_scheduler_if.sv | 41 ++++
 rtl/dmem_scheduler.sv | 101 ++++++++++
 tb/tb_dmem_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_scheduler_if.sv
`default_nettype none
// ============================================================================
// dmem_scheduler_if : requester, dmem and load-response bundle for dmem_scheduler
// Revision: 1.0
// ============================================================================
interface dmem_scheduler_if #(
  parameter int NUM_REQ       = 2,
  parameter int DMEM_ADDR_LEN = 8,
  parameter int ID_W          = 1
);
  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_we_i;
  logic [NUM_REQ*DMEM_ADDR_LEN-1:0] req_addr_i;
  logic [NUM_REQ*32-1:0]            req_wdata_i;
  logic [NUM_REQ*4-1:0]             req_wmask_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic                             mem_csb0_o;
  logic [3:0]                       mem_wmask0_o;
  logic [DMEM_ADDR_LEN-3:0]         mem_addr0_o;
  logic [31:0]                      mem_din0_o;
  logic                             mem_csb1_o;
  logic [DMEM_ADDR_LEN-3:0]         mem_addr1_o;
  logic [31:0]                      mem_dout1_i;
  logic                             rsp_valid_o;
  logic [ID_W-1:0]                  rsp_id_o;
  logic [31:0]                      rsp_data_o;

  // Requesters plus the dmem macro on one side, the scheduler on the other.
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, mem_dout1_i,
    input  req_ready_o, mem_csb0_o, mem_wmask0_o, mem_addr0_o, mem_din0_o,
    input  mem_csb1_o, mem_addr1_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, mem_dout1_i,
    output req_ready_o, mem_csb0_o, mem_wmask0_o, mem_addr0_o, mem_din0_o,
    output mem_csb1_o, mem_addr1_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_scheduler.sv
`default_nettype none
// ============================================================================
// dmem_scheduler : shares a 1W/1R dmem among NUM_REQ requesters, round-robin per port.
// Define SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority on both ports.
// Revision: 1.0
// ============================================================================
module dmem_scheduler #(
  parameter int NUM_REQ       = 2,
  parameter int DMEM_ADDR_LEN = 8,
  parameter int ID_W          = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  dmem_scheduler_if.slave bus
);
  localparam int WA = DMEM_ADDR_LEN - 2;

  // Returns {found, index} of the first candidate at or after ptr, modulo NUM_REQ.
  function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] cand,
                                         input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (|(cand & (NUM_REQ'(1) << j))) res = {1'b1, ID_W'(j)};
    end
    return res;
  endfunction

  logic [NUM_REQ-1:0] wr_cand, rd_cand;
  logic [ID_W-1:0]    wr_ptr, rd_ptr;
  logic [ID_W:0]      wr_pick, rd_pick;
  logic [ID_W-1:0]    wr_idx, rd_idx;
  logic               wr_gnt, rd_win, rd_gnt, hazard;
  logic [WA-1:0]      wr_word, rd_word;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;

  assign wr_cand = bus.req_valid_i & bus.req_we_i;
  assign rd_cand = bus.req_valid_i & ~bus.req_we_i;
  assign wr_pick = pick(wr_cand, wr_ptr);
  assign rd_pick = pick(rd_cand, rd_ptr);
  assign wr_idx  = wr_pick[ID_W-1:0];
  assign rd_idx  = rd_pick[ID_W-1:0];

  // Grants are gated by reset so ready/csb go inactive the moment reset asserts.
  assign wr_gnt  = reset_i & wr_pick[ID_W];
  assign rd_win  = reset_i & rd_pick[ID_W];

  assign wr_word = bus.req_addr_i[int'(wr_idx)*DMEM_ADDR_LEN + 2 +: WA];
  assign rd_word = bus.req_addr_i[int'(rd_idx)*DMEM_ADDR_LEN + 2 +: WA];

  // A read hitting the word being written this cycle waits so it sees the new data.
  assign hazard  = wr_gnt & rd_win & (wr_word == rd_word);
  assign rd_gnt  = rd_win & ~hazard;

  assign bus.req_ready_o  = ({NUM_REQ{wr_gnt}} & (NUM_REQ'(1) << wr_idx))
                          | ({NUM_REQ{rd_gnt}} & (NUM_REQ'(1) << rd_idx));
  assign bus.mem_csb0_o   = ~wr_gnt;
  assign bus.mem_addr0_o  = wr_word;
  assign bus.mem_din0_o   = bus.req_wdata_i[int'(wr_idx)*32 +: 32];
  assign bus.mem_wmask0_o = bus.req_wmask_i[int'(wr_idx)*4 +: 4];
  assign bus.mem_csb1_o   = ~rd_gnt;
  assign bus.mem_addr1_o  = rd_word;

`ifdef SCHED_FIXED_PRIO_EN
  assign wr_ptr = '0;
  assign rd_ptr = '0;
`else
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_gnt) wr_ptr <= next_ptr(wr_idx);
      if (rd_gnt) rd_ptr <= next_ptr(rd_idx);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= rd_gnt;
      if (rd_gnt) rsp_id <= rd_idx;
    end
  end

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = rsp_id;
  assign bus.rsp_data_o  = bus.mem_dout1_i;
endmodule
`default_nettype wire

// File: tb/tb_dmem_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dmem_scheduler : directed + randomized bench against a request-level reference model.
// Revision: 1.0
// ============================================================================
module tb_dmem_scheduler;
  localparam int N  = 2;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_scheduler_if #(.NUM_REQ(N), .DMEM_ADDR_LEN(AW), .ID_W(1)) bus  ();
  dmem_scheduler_if #(.NUM_REQ(3), .DMEM_ADDR_LEN(AW), .ID_W(2)) bus3 ();

  dmem_scheduler #(.NUM_REQ(N), .DMEM_ADDR_LEN(AW), .ID_W(1)) u_dut (
    .clk_i(clk), .reset_i(reset_n), .bus(bus.slave));
  dmem_scheduler #(.NUM_REQ(3), .DMEM_ADDR_LEN(AW), .ID_W(2)) u_dut3 (
    .clk_i(clk), .reset_i(reset_n), .bus(bus3.slave));

  assign bus3.mem_dout1_i = '0;

  // dmem macro: registered read, masked write
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!bus.mem_csb1_o) bus.mem_dout1_i <= mem[bus.mem_addr1_o];
    if (!bus.mem_csb0_o)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask0_o[b]) mem[bus.mem_addr0_o][8*b +: 8] = bus.mem_din0_o[8*b +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Current requests, one entry per requester
  logic [N-1:0] cv, cwe;
  logic [AW-1:0] cad [N];
  logic [31:0]   cwd [N];
  logic [3:0]    cwm [N];

  // Reference model state
  logic [31:0] ref_mem [64];
  int wptr, rptr, ew, er, exp_id;
  bit exp_valid;
  logic [31:0] exp_data;
  logic [N-1:0] exp_ready;

  logic [N-1:0] last_ready;
  logic [5:0]   last_addr1;
  logic [31:0]  last_rsp_data;

  task automatic model_reset();
    wptr = 0; rptr = 0; exp_valid = 0; exp_id = 0; exp_data = '0;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]          = cv[i];
      bus.req_we_i[i]             = cwe[i];
      bus.req_addr_i[i*AW +: AW]  = cad[i];
      bus.req_wdata_i[i*32 +: 32] = cwd[i];
      bus.req_wmask_i[i*4 +: 4]   = cwm[i];
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr,
                         input logic [31:0] d, input logic [3:0] m);
    cv[i] = v; cwe[i] = we; cad[i] = AW'(addr); cwd[i] = d; cwm[i] = m;
  endtask

  task automatic new_req(input int i);
    set_req(i, $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(31),
            $urandom, 4'($urandom_range(15)));
  endtask

  // Scan from the pointer for the first store and the first load; same word defers the load.
  task automatic model_eval();
    ew = -1; er = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (wptr + k) % N;
      if (ew < 0 && cv[j] && cwe[j]) ew = j;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rptr + k) % N;
      if (er < 0 && cv[j] && !cwe[j]) er = j;
    end
    if (ew >= 0 && er >= 0 && cad[ew][AW-1:2] == cad[er][AW-1:2]) er = -1;
    exp_ready = '0;
    if (ew >= 0) exp_ready[ew] = 1'b1;
    if (er >= 0) exp_ready[er] = 1'b1;
  endtask

  task automatic model_commit();
    if (er >= 0) begin
      exp_valid = 1; exp_id = er; exp_data = ref_mem[cad[er][AW-1:2]];
`ifndef SCHED_FIXED_PRIO_EN
      rptr = (er + 1) % N;
`endif
    end else begin
      exp_valid = 0;
    end
    if (ew >= 0) begin
      for (int b = 0; b < 4; b++)
        if (cwm[ew][b]) ref_mem[cad[ew][AW-1:2]][8*b +: 8] = cwd[ew][8*b +: 8];
`ifndef SCHED_FIXED_PRIO_EN
      wptr = (ew + 1) % N;
`endif
    end
  endtask

  task automatic run_cycle();
    drive_bus();
    model_eval();
    @(negedge clk);
    last_ready    = bus.req_ready_o;
    last_addr1    = bus.mem_addr1_o;
    last_rsp_data = bus.rsp_data_o;
    check_eq("ready", 64'(bus.req_ready_o), 64'(exp_ready));
    check_eq("csb0", 64'(bus.mem_csb0_o), 64'(ew < 0));
    check_eq("csb1", 64'(bus.mem_csb1_o), 64'(er < 0));
    if (ew >= 0) begin
      check_eq("addr0", 64'(bus.mem_addr0_o), 64'(cad[ew][AW-1:2]));
      check_eq("din0", 64'(bus.mem_din0_o), 64'(cwd[ew]));
      check_eq("wmask0", 64'(bus.mem_wmask0_o), 64'(cwm[ew]));
    end
    if (er >= 0) check_eq("addr1", 64'(bus.mem_addr1_o), 64'(cad[er][AW-1:2]));
    check_eq("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      check_eq("rsp_id", 64'(bus.rsp_id_o), 64'(exp_id));
      check_eq("rsp_data", 64'(bus.rsp_data_o), 64'(exp_data));
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
  endtask

  logic [N-1:0] rr_exp [4];
  logic [2:0]   wrap_exp [4];

  initial begin
`ifdef SCHED_FIXED_PRIO_EN
    rr_exp   = '{2'b01, 2'b01, 2'b01, 2'b01};
    wrap_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp   = '{2'b01, 2'b10, 2'b01, 2'b10};
    wrap_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    bus3.req_valid_i = '0; bus3.req_we_i = '0; bus3.req_addr_i = '0;
    bus3.req_wdata_i = '0; bus3.req_wmask_i = '0;
    clear_reqs();
    model_reset();
    reset_n = 1'b0;
    drive_bus();

    // Reset holds grants off even with a pending load
    repeat (3) @(posedge clk);
    #1;
    set_req(0, 1, 0, 8'h08, '0, '0);
    drive_bus();
    #1;
    check_eq("rst_ready", 64'(bus.req_ready_o), 64'(0));
    check_eq("rst_csb0", 64'(bus.mem_csb0_o), 64'(1));
    check_eq("rst_csb1", 64'(bus.mem_csb1_o), 64'(1));
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check_eq("rst_rsp_id", 64'(bus.rsp_id_o), 64'(0));
    @(negedge clk);
    clear_reqs();
    drive_bus();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_csb0", 64'(bus.mem_csb0_o), 64'(1));
    check_eq("post_rst_csb1", 64'(bus.mem_csb1_o), 64'(1));

    // Single load of byte 0x08 -> word 2
    set_req(0, 1, 0, 8'h08, '0, '0);
    run_cycle();
    check_eq("t2_addr1", 64'(last_addr1), 64'(2));
    clear_reqs();
    drive_bus();
    #2;
    check_eq("t2_rsp_pending", 64'(bus.rsp_valid_o), 64'(1));
    reset_n = 1'b0;
    #1;
    check_eq("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check_eq("midrst_rsp_id", 64'(bus.rsp_id_o), 64'(0));
    check_eq("midrst_csb1", 64'(bus.mem_csb1_o), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Parallel store and load
    set_req(0, 1, 1, 8'h04, 32'h1234_5678, 4'hF);
    set_req(1, 1, 0, 8'h10, '0, '0);
    run_cycle();
    check_eq("t3_ready", 64'(last_ready), 64'(2'b11));
    clear_reqs();
    run_cycle();

    // Same-word hazard: write first, deferred read returns the new data
    set_req(0, 1, 1, 8'h0C, 32'hDEAD_BEEF, 4'hF);
    set_req(1, 1, 0, 8'h0E, '0, '0);
    run_cycle();
    check_eq("t4_c0_ready", 64'(last_ready), 64'(2'b01));
    cv[0] = 1'b0;
    run_cycle();
    check_eq("t4_c1_ready", 64'(last_ready), 64'(2'b10));
    clear_reqs();
    run_cycle();
    check_eq("t4_rsp_data", 64'(last_rsp_data), 64'(32'hDEAD_BEEF));

    // Both requesters loading continuously
    set_req(0, 1, 0, 8'h20, '0, '0);
    set_req(1, 1, 0, 8'h24, '0, '0);
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      check_eq($sformatf("t5_grant%0d", c), 64'(last_ready), 64'(rr_exp[c]));
    end
    clear_reqs();
    run_cycle();

    // Randomized traffic; unaccepted requests are mostly held, occasionally dropped
    for (int i = 0; i < N; i++) new_req(i);
    for (int c = 0; c < 400; c++) begin
      run_cycle();
      for (int i = 0; i < N; i++) begin
        if (!cv[i] || ew == i || er == i) new_req(i);
        else if ($urandom_range(7) == 0) cv[i] = 1'b0;
      end
    end
    clear_reqs();
    run_cycle();

    // Three requesters all storing: pointer wraps 2 -> 0
    bus3.req_valid_i = 3'b111;
    bus3.req_we_i    = 3'b111;
    bus3.req_addr_i  = {8'h28, 8'h14, 8'h00};
    bus3.req_wmask_i = 12'hFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("wrap_grant%0d", c), 64'(bus3.req_ready_o), 64'(wrap_exp[c]));
      @(posedge clk);
      #1;
    end
    bus3.req_valid_i = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
